// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: shares the SD-card block-read port between the BGM and SFX
// streaming requesters. Grants whole sectors round-robin, issues the read
// command, steers returned bytes to the owner and aborts a stalled card.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no owner; waiting for sd_ready_in and a request
// ISSUE      | sd_rd_out asserted; waiting for the card to drop ready
// XFER       | streaming bytes to the owner; gap timer running
// WAIT_READY | sector complete (owner still granted) or abort cleanup;
//            | waiting for the card to raise ready again
// ABORT      | one-cycle timeout pulse; grant already dropped

module sd_read_arbiter #(
  parameter int          BLOCK_BYTES    = 512,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_485_000
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        bgm_req_in,
  input  logic [31:0] bgm_addr_in,
  input  logic        sfx_req_in,
  input  logic [31:0] sfx_addr_in,
  output logic        bgm_grant_out,
  output logic        sfx_grant_out,
  output logic [7:0]  data_out,
  output logic        bgm_valid_out,
  output logic        sfx_valid_out,
  output logic        bgm_done_out,
  output logic        sfx_done_out,
  output logic        timeout_out,
  output logic        busy_out,
  input  logic        sd_ready_in,
  output logic        sd_rd_out,
  output logic [31:0] sd_addr_out,
  input  logic        sd_byte_available_in,
  input  logic [7:0]  sd_dout_in
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_WAIT_READY,
    ST_ABORT
  } state_t;

  localparam logic [9:0]  BLOCK_CNT  = 10'(BLOCK_BYTES);
  localparam logic [9:0]  LAST_CNT   = 10'(BLOCK_BYTES - 1);
  localparam logic [23:0] TMO_LAST   = TIMEOUT_CYCLES - 24'd1;

  state_t      state_q, state_d;
  logic        last_sfx_q, last_sfx_d;     // 1: SFX held the port last
  logic        bgm_grant_q, bgm_grant_d;
  logic        sfx_grant_q, sfx_grant_d;
  logic        sd_rd_q, sd_rd_d;
  logic [31:0] sd_addr_q, sd_addr_d;
  logic [7:0]  data_q, data_d;
  logic        bgm_valid_d, sfx_valid_d;
  logic        bgm_done_d, sfx_done_d;
  logic        timeout_d;
  logic        bgm_valid_q, sfx_valid_q;
  logic        bgm_done_q, sfx_done_q;
  logic        timeout_q;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] tmo_cnt_q, tmo_cnt_d;

  logic        any_req;
  logic        pick_sfx;
  logic        tmo_expired;
  logic [23:0] tmo_cnt_inc;

  // Round-robin choice: SFX wins alone, or on a tie when BGM went last.
  assign any_req     = bgm_req_in | sfx_req_in;
  assign pick_sfx    = sfx_req_in & (~bgm_req_in | ~last_sfx_q);
  // Expiry is judged on the count before this edge, so the abort edge lands
  // exactly TIMEOUT_CYCLES edges after the counter was last cleared.
  assign tmo_expired = (tmo_cnt_q >= TMO_LAST);
  assign tmo_cnt_inc = (tmo_cnt_q == 24'hFF_FFFF) ? tmo_cnt_q : tmo_cnt_q + 24'd1;

  // Next-state and next-output decode; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    last_sfx_d  = last_sfx_q;
    bgm_grant_d = bgm_grant_q;
    sfx_grant_d = sfx_grant_q;
    sd_rd_d     = sd_rd_q;
    sd_addr_d   = sd_addr_q;
    data_d      = data_q;
    bgm_valid_d = 1'b0;
    sfx_valid_d = 1'b0;
    bgm_done_d  = 1'b0;
    sfx_done_d  = 1'b0;
    timeout_d   = 1'b0;
    byte_cnt_d  = byte_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sd_ready_in && any_req) begin
          if (pick_sfx) begin
            sfx_grant_d = 1'b1;
            sd_addr_d   = sfx_addr_in;
            last_sfx_d  = 1'b1;
          end else begin
            bgm_grant_d = 1'b1;
            sd_addr_d   = bgm_addr_in;
            last_sfx_d  = 1'b0;
          end
          sd_rd_d    = 1'b1;
          byte_cnt_d = '0;
          tmo_cnt_d  = '0;
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (!sd_ready_in) begin
          sd_rd_d   = 1'b0;
          tmo_cnt_d = '0;
          state_d   = ST_XFER;
        end else if (tmo_expired) begin
          sd_rd_d     = 1'b0;
          bgm_grant_d = 1'b0;
          sfx_grant_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = ST_ABORT;
        end else begin
          tmo_cnt_d = tmo_cnt_inc;
        end
      end

      ST_XFER: begin
        // A byte arriving on the expiry cycle still counts as a byte.
        if (sd_byte_available_in) begin
          data_d      = sd_dout_in;
          bgm_valid_d = bgm_grant_q;
          sfx_valid_d = sfx_grant_q;
          tmo_cnt_d   = '0;
          if (byte_cnt_q != BLOCK_CNT) begin
            byte_cnt_d = byte_cnt_q + 10'd1;
          end
          if (byte_cnt_q == LAST_CNT) begin
            bgm_done_d = bgm_grant_q;
            sfx_done_d = sfx_grant_q;
            state_d    = ST_WAIT_READY;
          end
        end else if (tmo_expired) begin
          bgm_grant_d = 1'b0;
          sfx_grant_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = ST_ABORT;
        end else begin
          tmo_cnt_d = tmo_cnt_inc;
        end
      end

      ST_WAIT_READY: begin
        if (sd_ready_in) begin
          bgm_grant_d = 1'b0;
          sfx_grant_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      ST_ABORT: begin
        state_d = ST_WAIT_READY;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer without pulses.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      last_sfx_q  <= 1'b0;
      bgm_grant_q <= 1'b0;
      sfx_grant_q <= 1'b0;
      sd_rd_q     <= 1'b0;
      sd_addr_q   <= '0;
      data_q      <= '0;
      bgm_valid_q <= 1'b0;
      sfx_valid_q <= 1'b0;
      bgm_done_q  <= 1'b0;
      sfx_done_q  <= 1'b0;
      timeout_q   <= 1'b0;
      byte_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_sfx_q  <= last_sfx_d;
      bgm_grant_q <= bgm_grant_d;
      sfx_grant_q <= sfx_grant_d;
      sd_rd_q     <= sd_rd_d;
      sd_addr_q   <= sd_addr_d;
      data_q      <= data_d;
      bgm_valid_q <= bgm_valid_d;
      sfx_valid_q <= sfx_valid_d;
      bgm_done_q  <= bgm_done_d;
      sfx_done_q  <= sfx_done_d;
      timeout_q   <= timeout_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign bgm_grant_out = bgm_grant_q;
  assign sfx_grant_out = sfx_grant_q;
  assign sd_rd_out     = sd_rd_q;
  assign sd_addr_out   = sd_addr_q;
  assign data_out      = data_q;
  assign bgm_valid_out = bgm_valid_q;
  assign sfx_valid_out = sfx_valid_q;
  assign bgm_done_out  = bgm_done_q;
  assign sfx_done_out  = sfx_done_q;
  assign timeout_out   = timeout_q;
  assign busy_out      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Bench for sd_read_arbiter: the bench plays the SD card and both requesters,
// and predicts ownership, byte steering and pulse counts from the arbitration
// rules (round-robin on ties, whole sectors, timeout after a silent window).

module tb_sd_read_arbiter;

  localparam int BGM = 0;
  localparam int SFX = 1;
  localparam int TMO = 100;
  localparam int BLK = 512;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        bgm_req_in, sfx_req_in;
  logic [31:0] bgm_addr_in, sfx_addr_in;
  logic        bgm_grant_out, sfx_grant_out;
  logic [7:0]  data_out;
  logic        bgm_valid_out, sfx_valid_out;
  logic        bgm_done_out, sfx_done_out;
  logic        timeout_out, busy_out;
  logic        sd_ready_in, sd_rd_out;
  logic [31:0] sd_addr_out;
  logic        sd_byte_available_in;
  logic [7:0]  sd_dout_in;

  int total = 0;
  int bad   = 0;
  int n_valid [2];
  int n_done  [2];
  int n_tmo   = 0;
  bit mon_en  = 0;
  int last_who;
  bit keep_req = 0;
  bit seq_data = 0;

  always #5 clk_in = ~clk_in;

  sd_read_arbiter #(.BLOCK_BYTES(BLK), .TIMEOUT_CYCLES(24'(TMO))) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .bgm_req_in(bgm_req_in), .bgm_addr_in(bgm_addr_in),
    .sfx_req_in(sfx_req_in), .sfx_addr_in(sfx_addr_in),
    .bgm_grant_out(bgm_grant_out), .sfx_grant_out(sfx_grant_out),
    .data_out(data_out),
    .bgm_valid_out(bgm_valid_out), .sfx_valid_out(sfx_valid_out),
    .bgm_done_out(bgm_done_out), .sfx_done_out(sfx_done_out),
    .timeout_out(timeout_out), .busy_out(busy_out),
    .sd_ready_in(sd_ready_in), .sd_rd_out(sd_rd_out), .sd_addr_out(sd_addr_out),
    .sd_byte_available_in(sd_byte_available_in), .sd_dout_in(sd_dout_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Per-cycle exclusivity and pulse tallies.
  always @(negedge clk_in) begin
    if (mon_en && !reset_in) begin
      if (bgm_valid_out) n_valid[BGM]++;
      if (sfx_valid_out) n_valid[SFX]++;
      if (bgm_done_out)  n_done[BGM]++;
      if (sfx_done_out)  n_done[SFX]++;
      if (timeout_out)   n_tmo++;
      chk("mutex_grant", 32'(bgm_grant_out & sfx_grant_out), 0);
      chk("mutex_valid", 32'(bgm_valid_out & sfx_valid_out), 0);
      chk("mutex_done",  32'(bgm_done_out & sfx_done_out), 0);
    end
  end

  // Reference arbitration: lone requester wins; a tie goes to whoever did not go last.
  function automatic int model_pick();
    if (bgm_req_in && sfx_req_in) return (last_who == BGM) ? SFX : BGM;
    else if (sfx_req_in) return SFX;
    else return BGM;
  endfunction

  task automatic wait_grant(output int who, output int lat);
    lat = 0;
    who = -1;
    do begin
      tick();
      lat++;
    end while (!(bgm_grant_out || sfx_grant_out) && lat < 50);
    if (bgm_grant_out) who = BGM;
    else if (sfx_grant_out) who = SFX;
    chk("grant_seen", 32'(bgm_grant_out | sfx_grant_out), 1);
  endtask

  task automatic xfer(input int who, input logic [31:0] exp_addr, input int nbytes,
                      input bit glitch, input int rst_at, output bit was_reset);
    logic [7:0] d;
    int hold;
    was_reset = 0;
    hold = $urandom_range(0, 3);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("rd_held", 32'(sd_rd_out), 1);
      chk("addr_held", sd_addr_out, exp_addr);
    end
    sd_ready_in = 0;
    tick();
    chk("rd_drop", 32'(sd_rd_out), 0);
    for (int i = 0; i < nbytes; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("valid_idle", 32'(bgm_valid_out | sfx_valid_out), 0);
      end
      if (glitch && i == 10) sfx_req_in = 1;
      if (glitch && i == 13) sfx_req_in = 0;
      d = seq_data ? 8'(i) : 8'($urandom);
      sd_dout_in = d;
      sd_byte_available_in = 1;
      tick();
      sd_byte_available_in = 0;
      if (i < BLK) begin
        chk("valid_own", 32'(who == BGM ? bgm_valid_out : sfx_valid_out), 1);
        chk("valid_other", 32'(who == BGM ? sfx_valid_out : bgm_valid_out), 0);
        chk("data", 32'(data_out), 32'(d));
        chk("done_own", 32'(who == BGM ? bgm_done_out : sfx_done_out), 32'(i == BLK - 1));
      end else begin
        chk("overrun_valid", 32'(bgm_valid_out | sfx_valid_out), 0);
      end
      if (i == rst_at) begin
        #2 reset_in = 1;
        #1;
        chk("rst_flags", 32'({bgm_grant_out, sfx_grant_out, bgm_valid_out, sfx_valid_out,
                              bgm_done_out, sfx_done_out, timeout_out, busy_out, sd_rd_out}), 0);
        chk("rst_addr", sd_addr_out, 0);
        chk("rst_data", 32'(data_out), 0);
        bgm_req_in  = 0;
        sfx_req_in  = 0;
        sd_ready_in = 1;
        tick();
        reset_in = 0;
        last_who = BGM;
        was_reset = 1;
        return;
      end
      if (i == BLK - 1 && !keep_req) begin
        if (who == BGM) bgm_req_in = 0;
        else sfx_req_in = 0;
      end
    end
    sd_ready_in = 1;
    tick();
    chk("grant_release", 32'(bgm_grant_out | sfx_grant_out), 0);
    chk("idle_after", 32'(busy_out), 0);
  endtask

  task automatic serve(input int nbytes, input bit glitch, input int rst_at);
    int exp_who, who, lat, v0b, v0s, d0b, d0s, t0, exp_v;
    bit r;
    exp_who = model_pick();
    wait_grant(who, lat);
    chk("grant_latency", lat, 1);
    chk("grant_who", who, exp_who);
    if (who < 0) return;
    last_who = who;
    chk("rd_issue", 32'(sd_rd_out), 1);
    chk("addr", sd_addr_out, (who == BGM) ? bgm_addr_in : sfx_addr_in);
    v0b = n_valid[BGM]; v0s = n_valid[SFX];
    d0b = n_done[BGM];  d0s = n_done[SFX];
    t0  = n_tmo;
    xfer(who, sd_addr_out, nbytes, glitch, rst_at, r);
    chk("timeout_count", n_tmo - t0, 0);
    if (r) begin
      chk("rst_no_done", (n_done[BGM] - d0b) + (n_done[SFX] - d0s), 0);
    end else begin
      exp_v = (nbytes < BLK) ? nbytes : BLK;
      chk("valid_count_own", (who == BGM) ? n_valid[BGM] - v0b : n_valid[SFX] - v0s, exp_v);
      chk("valid_count_other", (who == BGM) ? n_valid[SFX] - v0s : n_valid[BGM] - v0b, 0);
      chk("done_count_own", (who == BGM) ? n_done[BGM] - d0b : n_done[SFX] - d0s, 1);
      chk("done_count_other", (who == BGM) ? n_done[SFX] - d0s : n_done[BGM] - d0b, 0);
    end
  endtask

  task automatic do_reset();
    reset_in   = 1;
    bgm_req_in = 0;
    sfx_req_in = 0;
    sd_ready_in = 1;
    sd_byte_available_in = 0;
    tick();
    tick();
    reset_in = 0;
    last_who = BGM;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int who, lat, t0, d0, n;
    n_valid[BGM] = 0; n_valid[SFX] = 0;
    n_done[BGM]  = 0; n_done[SFX]  = 0;
    sd_dout_in = 0;
    bgm_addr_in = 32'h0000_0200;
    sfx_addr_in = 32'h0004_0000;
    reset_in = 1;
    bgm_req_in = 0;
    sfx_req_in = 0;
    sd_ready_in = 1;
    sd_byte_available_in = 0;
    tick();
    chk("reset_flags", 32'({bgm_grant_out, sfx_grant_out, bgm_valid_out, sfx_valid_out,
                            bgm_done_out, sfx_done_out, timeout_out, busy_out, sd_rd_out}), 0);
    chk("reset_addr", sd_addr_out, 0);
    chk("reset_data", 32'(data_out), 0);
    reset_in = 0;
    last_who = BGM;
    tick();
    chk("idle_no_req", 32'(busy_out | bgm_grant_out | sfx_grant_out), 0);
    mon_en = 1;

    // BGM alone, sequential data pattern.
    seq_data = 1;
    bgm_req_in = 1;
    serve(BLK, 0, -1);
    seq_data = 0;

    // SFX request blip during a BGM transfer is withdrawn before any grant.
    bgm_addr_in = 32'h0001_2400;
    bgm_req_in = 1;
    serve(BLK, 1, -1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("withdrawn_no_grant", 32'(bgm_grant_out | sfx_grant_out), 0);
    end

    // Ties after reset alternate starting with SFX.
    do_reset();
    bgm_req_in = 1;
    sfx_req_in = 1;
    serve(BLK, 0, -1);
    serve(BLK, 0, -1);
    bgm_req_in = 1;
    sfx_req_in = 1;
    serve(BLK, 0, -1);

    // Card over-runs the sector by three bytes.
    serve(BLK + 3, 0, -1);

    // Card never drops ready: timeout, then a pending SFX request is served.
    bgm_req_in = 1;
    sfx_req_in = 0;
    chk("stall_pick", model_pick(), BGM);
    wait_grant(who, lat);
    chk("stall_grant", who, BGM);
    last_who = BGM;
    t0 = n_tmo;
    d0 = n_done[BGM] + n_done[SFX];
    sfx_req_in = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!timeout_out && n < 300);
    chk("timeout_cycles", n, TMO);
    chk("abort_grant", 32'(bgm_grant_out | sfx_grant_out), 0);
    chk("abort_rd", 32'(sd_rd_out), 0);
    bgm_req_in = 0;
    sd_ready_in = 0;
    tick();
    chk("timeout_width", 32'(timeout_out), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_wait_no_grant", 32'(bgm_grant_out | sfx_grant_out), 0);
    end
    chk("abort_timeout_count", n_tmo - t0, 1);
    chk("abort_no_done", n_done[BGM] + n_done[SFX] - d0, 0);
    sd_ready_in = 1;
    wait_grant(who, lat);
    chk("regrant_who", who, SFX);
    chk("regrant_latency", lat, 2);
    last_who = who;
    begin
      bit r;
      d0 = n_done[SFX];
      xfer(who, sfx_addr_in, BLK, 0, -1, r);
      chk("regrant_done", n_done[SFX] - d0, 1);
    end

    // Reset in the middle of a sector, then a fresh full sector.
    bgm_addr_in = 32'h00A0_0000;
    bgm_req_in = 1;
    serve(BLK, 0, 200);
    bgm_req_in = 1;
    serve(BLK, 0, -1);

    // Randomized request patterns, sometimes holding req through done.
    for (int it = 0; it < 4; it++) begin
      if (!bgm_req_in && !sfx_req_in) begin
        int pat;
        pat = $urandom_range(1, 3);
        bgm_req_in = pat[0];
        sfx_req_in = pat[1];
      end
      bgm_addr_in = $urandom & 32'hFFFF_FE00;
      sfx_addr_in = $urandom & 32'hFFFF_FE00;
      keep_req = 1'($urandom_range(0, 1));
      serve(BLK + $urandom_range(0, 2), 0, -1);
    end
    keep_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Shares the single SD-card block-read port between two streaming requesters: background music (BGM) and sound effects (SFX).
- Sits inside the SD/audio subsystem, between the per-stream sample buffers and the SD card controller.
- Grants whole 512-byte sector reads, issues the read command, and steers each returned byte to the granted requester.
- Counts bytes, signals completion, and recovers from a stalled card via a timeout.

Parameters:
BLOCK_BYTES, 512, bytes per sector read; the counter is 10 bits wide.
TIMEOUT_CYCLES, 24'd1_485_000, idle cycles allowed in ISSUE, or between bytes in XFER, before abort (10 ms at 148.5 MHz).

Ports:
clk_in  input  1  system clock (148.5 MHz domain)
reset_in  input  1  asynchronous, active-high reset
bgm_req_in  input  1  BGM requests one sector; level, held until bgm_done_out or withdrawn
bgm_addr_in  input  32  BGM sector byte address
sfx_req_in  input  1  SFX requests one sector; level
sfx_addr_in  input  32  SFX sector byte address
bgm_grant_out  output  1  BGM owns the SD port
sfx_grant_out  output  1  SFX owns the SD port
data_out  output  8  byte returned from the card (shared by both requesters)
bgm_valid_out  output  1  data_out valid for BGM; 1-cycle pulse
sfx_valid_out  output  1  data_out valid for SFX; 1-cycle pulse
bgm_done_out  output  1  BGM sector complete; 1-cycle pulse
sfx_done_out  output  1  SFX sector complete; 1-cycle pulse
timeout_out  output  1  transfer aborted; 1-cycle pulse
busy_out  output  1  state != IDLE
sd_ready_in  input  1  SD controller ready for a command
sd_rd_out  output  1  read command to the SD controller
sd_addr_out  output  32  read address to the SD controller
sd_byte_available_in  input  1  byte strobe; 1-cycle pulse, already in the clk_in domain
sd_dout_in  input  8  byte from the SD controller

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0; state IDLE; byte counter 0; timeout counter 0.
  - Round-robin pointer last_grant = BGM, so SFX wins the first tie.
  - Reset mid-transfer abandons the transfer immediately. No done or timeout pulse is produced.
- IDLE:
  - Waits until sd_ready_in=1 and at least one request is high.
  - Single requester: that requester is granted.
  - Both requesters: the one that is not last_grant is granted (round-robin).
  - On grant: register the winner's address into sd_addr_out, set that grant, update last_grant, go to ISSUE.
  - Grant is visible the cycle after the decision.
- ISSUE:
  - sd_rd_out=1 and sd_addr_out held stable.
  - When sd_ready_in=0: drop sd_rd_out, clear the timeout counter, go to XFER.
  - If the timeout counter reaches TIMEOUT_CYCLES first: go to ABORT.
- XFER, on each sd_byte_available_in pulse:
  - Next cycle: data_out <= sd_dout_in and the granted stream's valid pulses. Latency is 1 cycle.
  - Byte counter increments; timeout counter clears.
  - On byte BLOCK_BYTES, the granted done pulses in the same cycle as its last valid. Then go to WAIT_READY.
  - A gap of TIMEOUT_CYCLES cycles without a byte: go to ABORT.
- WAIT_READY:
  - Bytes arriving here are ignored: no valid pulse.
  - When sd_ready_in=1: drop the grant, go to IDLE.
  - Earliest next grant is the following cycle.
- ABORT:
  - timeout_out pulses for 1 cycle; the grant drops; no done pulse.
  - The byte counter does not reset the card.
  - Go to WAIT_READY-equivalent behaviour: wait for sd_ready_in=1 before IDLE, without holding any grant.
- Request rules:
  - Deasserting a req before grant withdraws it.
  - Deasserting a req after grant is ignored; the sector completes.
  - A requester that holds req high through its done pulse is treated as a new request in IDLE. Round-robin still applies.
- Mutual exclusion: at most one grant, one valid and one done asserted in any cycle.
- Widths and wrap:
  - The byte counter never wraps; it saturates at BLOCK_BYTES until cleared on entry to ISSUE.
  - The timeout counter saturates.
- Simultaneous events: a byte pulse in the same cycle as timeout expiry counts as a byte. Timeout is evaluated after the counter clears.

Test Plan:
- BGM only: bgm_req=1, addr 0x0000_0200, model returns 512 bytes 0x00..0xFF repeating.
  - Required: sd_addr_out=0x200; sd_rd_out high until ready falls.
  - Required: 512 bgm_valid pulses, each 1 cycle after its strobe, data matching the sequence.
  - Required: bgm_done on the 512th; sfx outputs stay 0.
- Tie after reset: both req rise in the same cycle.
  - Required: SFX granted first; BGM granted immediately after SFX completes and ready returns.
  - A third tie then grants SFX.
- Withdrawal: sfx_req pulses for 3 cycles while a BGM transfer is in XFER.
  - Required: no SFX grant after BGM completes.
- Stall: the card never drops ready after sd_rd_out.
  - Required: timeout_out pulse exactly TIMEOUT_CYCLES cycles later (use TIMEOUT_CYCLES=100), grant drops, no done.
  - Required: a pending request is granted once ready=1.
- Over-run: the model sends 515 bytes.
  - Required: exactly 512 valid pulses and a single done pulse.
- Reset at byte 200: assert reset_in asynchronously.
  - Required: all outputs 0 before the next edge, state IDLE, no done or timeout pulse.
  - A new request after reset starts at byte count 0.
